delta_distance_calc: RTL
========================

Name: delta_distance_calc

Overview:
- Upstream neighbour of the metropolis test stage. Takes a candidate move (2-opt or or-opt) as opt_t {command, K, L}.
- Fetches the affected cities from the replica's ordinal (route) memory and fetches the edge lengths from the distance memory.
- Accumulates the signed route-length change, then presents delta_distance and the matching opt_t for one cycle.

Parameters:
- NCITY, 30, number of cities = route length; positions 0..NCITY-1, wrap modulo NCITY.
- CITY_W, $clog2(NCITY), width of position and city indices.
- DIST_W, 24, unsigned distance width, 17 fractional bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low (0 = reset).
- in_valid  in  1  move request valid.
- in_ready  out  1  block idle, can accept a request.
- in_opt  in  opt_t  command/K/L of the request.
- ordinal_addr  out  CITY_W  route position to read.
- ordinal_data  in  CITY_W  city at that position, 1-cycle read latency.
- distance_a  out  CITY_W  first city of the edge.
- distance_b  out  CITY_W  second city of the edge.
- distance_data  in  DIST_W  edge length, 1-cycle latency; d(x,x)=0, symmetric.
- out_valid  out  1  one-cycle pulse, result valid.
- out_opt  out  opt_t  registered copy of the accepted in_opt.
- delta_distance  out  delata_data_t  signed new-minus-old length.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; in_ready=1; out_valid=0; delta_distance=0; out_opt={THR,0,0}; accumulator cleared.
- Reset mid-operation: abandon the move. No out_valid is produced; in_ready=1 from the first cycle reset is high again.
- Accept: in_valid && in_ready at cycle 0. Latch in_opt and go to FETCH. in_ready=0 until the cycle after out_valid; in_valid while busy is ignored.
- Move type: in_opt.command==TWO is 2-opt; any other command is or-opt. The command passes through to out_opt unchanged; the OR0/OR1 choice belongs downstream.
- Position arithmetic: K-1, K+1 and L+1 wrap modulo NCITY (position -1 maps to NCITY-1, position NCITY maps to 0).
- 2-opt, reversing K+1..L:
  - FETCH reads positions K, K+1, L, L+1 on cycles 1-4.
  - DIST issues edges (cK,cL)+, (cK+1,cL+1)+, (cK,cK+1)-, (cL,cL+1)- on cycles 6-9 and accumulates on cycles 7-10.
  - out_valid at cycle 11.
- Or-opt, moving city K to just after L:
  - FETCH reads K-1, K, K+1, L, L+1 on cycles 1-5.
  - DIST issues (cK-1,cK+1)+, (cL,cK)+, (cK,cL+1)+, (cK-1,cK)-, (cK,cK+1)-, (cL,cL+1)- on cycles 7-12 and accumulates on cycles 8-13.
  - out_valid at cycle 14.
- States: IDLE -> FETCH -> DIST -> DONE -> IDLE. DONE lasts one cycle and drives out_valid=1. Latency is fixed per move type and independent of the data.
- Null or-opt (L==K or L==K-1 mod NCITY): run the full sequence but force delta_distance=0. Latency stays 14.
- Degenerate 2-opt (L==K+1) needs no special case; the formula yields 0.
- Arithmetic:
  - Accumulator and delta_distance are signed, DIST_W+3 bits, which is exactly the width of delata_data_t.
  - Each distance is zero-extended before add or subtract. The width cannot overflow for 6 terms; no saturation.
- Outputs delta_distance and out_opt hold their value after out_valid until the next result.
- ordinal_addr, distance_a and distance_b are don't-care outside their issue cycles; they are held at the last value.

Decomposition:
- replica_pkg holds:
  - opt_t and the command enum (THR, TWO, OR0, OR1, PREV, FOLW as used by the exchange logic);
  - delata_data_t;
  - a city_t typedef sized from NCITY;
  - the DIST_FRAC=17 constant.
- One natural sub-module: delta_term_table. It is combinational and maps (move type, step index) to (position selector, edge endpoints selector, sign). The sequencer then only counts steps.

Test Plan:
- Common setup, all scenarios: NCITY=8; route c[i]=i; d(a,b)=|a-b|<<17.
- 2-opt {TWO,K=1,L=4} accepted at cycle 0 -> out_valid only at cycle 11; delta_distance=+4<<17=0x80000; out_opt={TWO,1,4}; in_ready=1 at cycle 12.
- Or-opt {OR0,K=2,L=5} -> out_valid at cycle 14; delta=(2+3+4-1-1-1)<<17=0xC0000.
- Wrap: or-opt K=0,L=3 -> ordinal reads 7,0,1,3,4; delta=(6+3+4-7-1-1)<<17=0x80000.
- Null move: or-opt K=3,L=3 and or-opt K=3,L=2 -> delta=0 at cycle 14, out_valid still pulsed once.
- Reset mid-op: reset=0 at cycle 5 of a 2-opt -> no out_valid ever for that move; in_ready=1 and out_opt.command=THR after release; the next request completes normally.
- Back-to-back: in_valid held high with two 2-opt moves -> second accepted at cycle 12, its out_valid at cycle 23; no request is lost or duplicated.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types and constants for the replica datapath.
//   command_t     : move command carried with every candidate move
//   opt_t         : {command, K, L} candidate move descriptor
//   city_t        : route position / city index
//   delata_data_t : signed route-length change (new minus old)
//   pos_sel_t     : selects one of the fetched cities around K and L
package replica_pkg;

  localparam int unsigned NCITY_DEF = 30;
  localparam int unsigned CITY_W    = $clog2(NCITY_DEF);
  localparam int unsigned DIST_W    = 24;
  localparam int unsigned DIST_FRAC = 17;
  localparam int unsigned DELTA_W   = DIST_W + 3;

  typedef logic [CITY_W-1:0]         city_t;
  typedef logic signed [DELTA_W-1:0] delata_data_t;
  typedef logic [2:0]                step_t;

  typedef enum logic [2:0] {
    THR  = 3'd0,
    TWO  = 3'd1,
    OR0  = 3'd2,
    OR1  = 3'd3,
    PREV = 3'd4,
    FOLW = 3'd5
  } command_t;

  typedef struct packed {
    command_t command;
    city_t    K;
    city_t    L;
  } opt_t;

  typedef enum logic [2:0] {
    SEL_KM1 = 3'd0,
    SEL_K   = 3'd1,
    SEL_KP1 = 3'd2,
    SEL_L   = 3'd3,
    SEL_LP1 = 3'd4
  } pos_sel_t;

  // Route reads and edge terms per move type.
  localparam step_t NFETCH_TWO = 3'd4;
  localparam step_t NFETCH_OR  = 3'd5;
  localparam step_t NTERM_TWO  = 3'd4;
  localparam step_t NTERM_OR   = 3'd6;

endpackage

// File: rtl/delta_distance_calc_term_table.sv
// Combinational step table for the delta-distance sequencer.
//   i_two     : 1 = 2-opt move, 0 = or-opt move
//   i_step    : step index (fetch step or edge-term index)
//   o_pos_sel : route position to read at this fetch step
//   o_ea_sel  : first endpoint of the edge at this term step
//   o_eb_sel  : second endpoint of the edge at this term step
//   o_sub     : 1 = edge is removed (subtract), 0 = edge is added
module delta_term_table
  import replica_pkg::*;
(
  input  logic     i_two,
  input  step_t    i_step,
  output pos_sel_t o_pos_sel,
  output pos_sel_t o_ea_sel,
  output pos_sel_t o_eb_sel,
  output logic     o_sub
);

  always_comb begin
    o_pos_sel = SEL_K;
    o_ea_sel  = SEL_K;
    o_eb_sel  = SEL_K;
    o_sub     = 1'b0;
    if (i_two) begin
      // Reverse K+1..L: add (K,L),(K+1,L+1); remove (K,K+1),(L,L+1).
      case (i_step)
        3'd0: begin o_pos_sel = SEL_K;   o_ea_sel = SEL_K;   o_eb_sel = SEL_L;                end
        3'd1: begin o_pos_sel = SEL_KP1; o_ea_sel = SEL_KP1; o_eb_sel = SEL_LP1;              end
        3'd2: begin o_pos_sel = SEL_L;   o_ea_sel = SEL_K;   o_eb_sel = SEL_KP1; o_sub = 1'b1; end
        3'd3: begin o_pos_sel = SEL_LP1; o_ea_sel = SEL_L;   o_eb_sel = SEL_LP1; o_sub = 1'b1; end
        default: ;
      endcase
    end else begin
      // Move city K after L: add (K-1,K+1),(L,K),(K,L+1); remove (K-1,K),(K,K+1),(L,L+1).
      case (i_step)
        3'd0: begin o_pos_sel = SEL_KM1; o_ea_sel = SEL_KM1; o_eb_sel = SEL_KP1;              end
        3'd1: begin o_pos_sel = SEL_K;   o_ea_sel = SEL_L;   o_eb_sel = SEL_K;                end
        3'd2: begin o_pos_sel = SEL_KP1; o_ea_sel = SEL_K;   o_eb_sel = SEL_LP1;              end
        3'd3: begin o_pos_sel = SEL_L;   o_ea_sel = SEL_KM1; o_eb_sel = SEL_K;   o_sub = 1'b1; end
        3'd4: begin o_pos_sel = SEL_LP1; o_ea_sel = SEL_K;   o_eb_sel = SEL_KP1; o_sub = 1'b1; end
        3'd5: begin                      o_ea_sel = SEL_L;   o_eb_sel = SEL_LP1; o_sub = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/delta_distance_calc.sv
// Computes the signed route-length change of a candidate 2-opt / or-opt move.
//   clk, reset     : clock, synchronous active-low reset
//   in_valid/ready : move request handshake, in_opt = {command, K, L}
//   ordinal_addr   : route position to read; ordinal_data returns 1 cycle later
//   distance_a/b   : edge endpoints; distance_data returns 1 cycle later
//   out_valid      : one-cycle result pulse
//   out_opt        : accepted move, held until next result
//   delta_distance : new-minus-old length, held until next result
module delta_distance_calc
  import replica_pkg::*;
#(
  parameter int unsigned NCITY = NCITY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  opt_t              in_opt,
  output logic [CITY_W-1:0] ordinal_addr,
  input  logic [CITY_W-1:0] ordinal_data,
  output logic [CITY_W-1:0] distance_a,
  output logic [CITY_W-1:0] distance_b,
  input  logic [DIST_W-1:0] distance_data,
  output logic              out_valid,
  output opt_t              out_opt,
  output delata_data_t      delta_distance
);

  typedef enum logic [1:0] {IDLE, FETCH, DIST, DONE} state_t;

  state_t       r_state;
  opt_t         r_opt;
  step_t        r_step;
  logic         r_rd_vld, r_cap_vld;
  pos_sel_t     r_rd_sel, r_cap_sel;
  logic         r_iss_vld, r_iss_sub, r_acc_vld, r_acc_sub;
  delata_data_t r_acc;
  city_t        r_city [5];

  logic         w_two, w_sub, w_null;
  city_t        w_k, w_l, w_pos_city;
  step_t        w_step, w_nf, w_nt;
  pos_sel_t     w_pos_sel, w_ea_sel, w_eb_sel;
  delata_data_t w_term, w_acc_next;

  function automatic city_t pos_dec(input city_t p);
    return (p == '0) ? city_t'(NCITY - 1) : p - city_t'(1);
  endfunction

  function automatic city_t pos_inc(input city_t p);
    return (p == city_t'(NCITY - 1)) ? '0 : p + city_t'(1);
  endfunction

  // The first read is issued on the accept edge, before in_opt is latched.
  always_comb begin
    w_two = (r_state == IDLE) ? (in_opt.command == TWO) : (r_opt.command == TWO);
    w_k   = (r_state == IDLE) ? in_opt.K : r_opt.K;
    w_l   = (r_state == IDLE) ? in_opt.L : r_opt.L;
    w_nf  = w_two ? NFETCH_TWO : NFETCH_OR;
    w_nt  = w_two ? NTERM_TWO  : NTERM_OR;
    // The last FETCH cycle issues edge term 0 while the final read lands.
    if (r_state == IDLE || (r_state == FETCH && r_step == w_nf + 3'd1))
      w_step = '0;
    else
      w_step = r_step;
  end

  delta_term_table u_term_table (
    .i_two     (w_two),
    .i_step    (w_step),
    .o_pos_sel (w_pos_sel),
    .o_ea_sel  (w_ea_sel),
    .o_eb_sel  (w_eb_sel),
    .o_sub     (w_sub)
  );

  always_comb begin
    w_pos_city = w_k;
    case (w_pos_sel)
      SEL_KM1: w_pos_city = pos_dec(w_k);
      SEL_K:   w_pos_city = w_k;
      SEL_KP1: w_pos_city = pos_inc(w_k);
      SEL_L:   w_pos_city = w_l;
      SEL_LP1: w_pos_city = pos_inc(w_l);
      default: w_pos_city = w_k;
    endcase
  end

  always_comb begin
    w_null     = (r_opt.command != TWO) &&
                 ((r_opt.L == r_opt.K) || (r_opt.L == pos_dec(r_opt.K)));
    w_term     = delata_data_t'({3'b000, distance_data});
    w_acc_next = r_acc;
    if (r_acc_vld)
      w_acc_next = r_acc_sub ? (r_acc - w_term) : (r_acc + w_term);
  end

  // Edge term 0 never needs the city captured on the same edge (always L+1),
  // so the city registers need no bypass from ordinal_data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      delta_distance <= '0;
      out_opt        <= '{command: THR, K: '0, L: '0};
      r_opt          <= '{command: THR, K: '0, L: '0};
      r_acc          <= '0;
      r_step         <= '0;
      r_rd_vld       <= 1'b0;
      r_cap_vld      <= 1'b0;
      r_rd_sel       <= SEL_K;
      r_cap_sel      <= SEL_K;
      r_iss_vld      <= 1'b0;
      r_iss_sub      <= 1'b0;
      r_acc_vld      <= 1'b0;
      r_acc_sub      <= 1'b0;
      ordinal_addr   <= '0;
      distance_a     <= '0;
      distance_b     <= '0;
      for (int unsigned i = 0; i < 5; i++) r_city[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      r_cap_vld <= r_rd_vld;
      r_cap_sel <= r_rd_sel;
      if (r_cap_vld) r_city[r_cap_sel] <= ordinal_data;
      r_acc_vld <= r_iss_vld;
      r_acc_sub <= r_iss_sub;
      r_acc     <= w_acc_next;
      r_rd_vld  <= 1'b0;
      r_iss_vld <= 1'b0;

      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_opt        <= in_opt;
            r_state      <= FETCH;
            in_ready     <= 1'b0;
            r_step       <= 3'd1;
            r_acc        <= '0;
            ordinal_addr <= w_pos_city;
            r_rd_sel     <= w_pos_sel;
            r_rd_vld     <= 1'b1;
          end
        end
        FETCH: begin
          r_step <= r_step + 3'd1;
          if (r_step < w_nf) begin
            ordinal_addr <= w_pos_city;
            r_rd_sel     <= w_pos_sel;
            r_rd_vld     <= 1'b1;
          end else if (r_step == w_nf + 3'd1) begin
            r_state    <= DIST;
            r_step     <= 3'd1;
            distance_a <= r_city[w_ea_sel];
            distance_b <= r_city[w_eb_sel];
            r_iss_vld  <= 1'b1;
            r_iss_sub  <= w_sub;
          end
        end
        DIST: begin
          r_step <= r_step + 3'd1;
          if (r_step < w_nt) begin
            distance_a <= r_city[w_ea_sel];
            distance_b <= r_city[w_eb_sel];
            r_iss_vld  <= 1'b1;
            r_iss_sub  <= w_sub;
          end else if (r_step == w_nt + 3'd1) begin
            r_state        <= DONE;
            out_valid      <= 1'b1;
            out_opt        <= r_opt;
            delta_distance <= w_null ? '0 : w_acc_next;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          in_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
